ms_latch_buf: RTL and testbench

//  Parametrised successor to the fixed 10-bit gated capture latch bank. Captures a

---
 rtl/ms_latch_buf.sv | 108 ++++++++++
 tb/tb_ms_latch_buf.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ms_latch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ms_latch_buf
//  Function : Gated capture register bank feeding a DEPTH-entry FIFO with
//             valid/pop handshake, hold/freeze, occupancy and sticky overflow.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module ms_latch_buf #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             g,
   input  logic [WIDTH-1:0] d_in,
   input  logic             hold,
   input  logic             pop,
   input  logic             ovf_clr,
   output logic [WIDTH-1:0] d_out,
   output logic             out_valid,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] C_LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;

   logic w_pop_eff;
   logic w_push;
   logic w_drop;

   // Status is derived from the registered count so it never glitches with inputs.
   assign out_valid = (count_q != '0);
   assign full      = (count_q == C_DEPTH);
   assign count     = count_q;
   assign ovf       = ovf_q;
   assign d_out     = mem_q[rd_ptr_q];

   always_comb begin
      w_pop_eff = pop & ~hold & out_valid;
      // A pop on the same edge frees the head slot, so a full buffer still accepts.
      w_push    = g & ~hold & (~full | w_pop_eff);
      w_drop    = g & ~hold & full & ~w_pop_eff;
   end

   always_comb begin
      mem_d = mem_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = d_in;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (w_push) begin
         wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      if (w_pop_eff) begin
         rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({w_push, w_pop_eff})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Set has priority over clear; clear is honoured even while frozen.
   always_comb begin
      ovf_d = w_drop | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ms_latch_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ms_latch_buf
//  Function : Self-checking bench for ms_latch_buf (queue reference model,
//             directed vector table, corner sequences, random traffic).
//  Revision : 1.0
// ============================================================================
module tb_ms_latch_buf;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             reset;
   logic             g, hold, pop, ovf_clr;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d_out;
   logic             out_valid, full, ovf;
   logic [CW-1:0]    count;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] mq[$];
   logic             m_ovf;

   typedef struct {
      logic             g;
      logic [WIDTH-1:0] d;
      logic             hold;
      logic             pop;
      logic             clr;
      int               cnt;
      logic             ovf;
      logic [WIDTH-1:0] dout;
   } vec_t;

   vec_t tbl[22];

   ms_latch_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .g(g), .d_in(d_in), .hold(hold), .pop(pop),
      .ovf_clr(ovf_clr), .d_out(d_out), .out_valid(out_valid), .full(full),
      .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (mq.size() != 0) chk("d_out", 32'(d_out), 32'(mq[0]));
   endtask

   // One clock: drive, let the edge happen, advance the model, compare.
   task automatic step(input logic sg, input logic [WIDTH-1:0] sd, input logic sh,
                       input logic sp, input logic sc);
      bit pe, pu, dr, was_full;
      g = sg; d_in = sd; hold = sh; pop = sp; ovf_clr = sc;
      @(posedge clk);
      was_full = (mq.size() == DEPTH);
      pe = sp && !sh && (mq.size() != 0);
      pu = sg && !sh && (!was_full || pe);
      dr = sg && !sh && was_full && !pe;
      if (pe) void'(mq.pop_front());
      if (pu) mq.push_back(sd);
      m_ovf = dr || (m_ovf && !sc);
      #1;
      model_check();
   endtask

   function automatic vec_t mk(input logic sg, input int sd, input logic sp, input logic sc,
                               input int cnt, input logic eo, input int dout);
      vec_t v;
      v.g = sg; v.d = WIDTH'(sd); v.hold = 1'b0; v.pop = sp; v.clr = sc;
      v.cnt = cnt; v.ovf = eo; v.dout = WIDTH'(dout);
      return v;
   endfunction

   initial begin
      // Fill/drain, empty pop, overflow, ovf_clr vs. new drop, full push+pop.
      tbl[0]  = mk(1, 'h001, 0, 0, 1, 0, 'h001);
      tbl[1]  = mk(1, 'h002, 0, 0, 2, 0, 'h001);
      tbl[2]  = mk(1, 'h003, 0, 0, 3, 0, 'h001);
      tbl[3]  = mk(1, 'h004, 0, 0, 4, 0, 'h001);
      tbl[4]  = mk(0, 0,     1, 0, 3, 0, 'h002);
      tbl[5]  = mk(0, 0,     1, 0, 2, 0, 'h003);
      tbl[6]  = mk(0, 0,     1, 0, 1, 0, 'h004);
      tbl[7]  = mk(0, 0,     1, 0, 0, 0, 0);
      tbl[8]  = mk(0, 0,     1, 0, 0, 0, 0);
      tbl[9]  = mk(1, 'h001, 0, 0, 1, 0, 'h001);
      tbl[10] = mk(1, 'h002, 0, 0, 2, 0, 'h001);
      tbl[11] = mk(1, 'h003, 0, 0, 3, 0, 'h001);
      tbl[12] = mk(1, 'h004, 0, 0, 4, 0, 'h001);
      tbl[13] = mk(1, 'h3FF, 0, 0, 4, 1, 'h001);
      tbl[14] = mk(0, 0,     0, 1, 4, 0, 'h001);
      tbl[15] = mk(1, 'h3FF, 0, 1, 4, 1, 'h001);
      tbl[16] = mk(0, 0,     0, 1, 4, 0, 'h001);
      tbl[17] = mk(1, 'h155, 1, 0, 4, 0, 'h002);
      tbl[18] = mk(0, 0,     1, 0, 3, 0, 'h003);
      tbl[19] = mk(0, 0,     1, 0, 2, 0, 'h004);
      tbl[20] = mk(0, 0,     1, 0, 1, 0, 'h155);
      tbl[21] = mk(0, 0,     1, 0, 0, 0, 0);

      reset = 1'b1; g = 0; d_in = '0; hold = 0; pop = 0; ovf_clr = 0;
      m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_dout", 32'(d_out), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(ovf), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 22; i++) begin
         step(tbl[i].g, tbl[i].d, tbl[i].hold, tbl[i].pop, tbl[i].clr);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_ovf", i), 32'(ovf), 32'(tbl[i].ovf));
         if (tbl[i].cnt != 0) chk($sformatf("tbl%0d_dout", i), 32'(d_out), 32'(tbl[i].dout));
         else chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 0);
      end

      // Hold: two entries frozen while g and pop are both requested.
      step(1, 16'h00AA, 0, 0, 0);
      step(1, 16'h00BB, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 16'h00CC, 1, 1, 0);
         chk("hold_count", 32'(count), 2);
         chk("hold_dout", 32'(d_out), 32'h00AA);
         chk("hold_ovf", 32'(ovf), 0);
      end
      step(0, 0, 0, 1, 0);
      chk("unhold_dout", 32'(d_out), 32'h00BB);
      step(0, 0, 0, 1, 0);

      // Hold does not count drops, but ovf_clr still works while frozen.
      for (int i = 0; i < DEPTH; i++) step(1, WIDTH'(16'h0A0 + i), 0, 0, 0);
      step(1, 16'hDEAD, 0, 0, 0);
      step(1, 16'hBEEF, 1, 0, 1);
      chk("hold_clr_ovf", 32'(ovf), 0);
      step(1, 16'hBEEF, 1, 0, 0);
      chk("hold_nodrop_ovf", 32'(ovf), 0);

      // Async reset with three entries queued and ovf set.
      step(1, 16'h1234, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("pre_rst_count", 32'(count), 3);
      chk("pre_rst_ovf", 32'(ovf), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_count", 32'(count), 0);
      chk("async_valid", 32'(out_valid), 0);
      chk("async_dout", 32'(d_out), 0);
      chk("async_ovf", 32'(ovf), 0);
      mq.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Empty pop must not move the read pointer.
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      step(1, 16'h5A5A, 0, 0, 0);
      chk("after_empty_pop_dout", 32'(d_out), 32'h5A5A);
      step(0, 0, 0, 1, 0);

      // Random traffic against the queue model, many wraps of the pointers.
      for (int i = 0; i < 40 * DEPTH; i++) begin
         step(1'($urandom_range(0, 1)), WIDTH'($urandom),
              1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
